// File: rtl/wb_block_reader.sv
// Pipelined Wishbone block reader: fetches len consecutive words starting at base
// and streams them out through a small FIFO, with credit-based request throttling.
module wb_block_reader #(
    parameter int AW    = 16,
    parameter int DW    = 16,
    parameter int LW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [AW-1:0] wb_adr_o,
    input  logic [DW-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_stall_i
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FIN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [LW-1:0] rem_q, rem_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] wptr_q, rptr_q;
    logic [DW-1:0] mem_q [DEPTH];

    logic [CW:0] credit_sum;
    logic        credit_ok;
    logic        issue;
    logic        ack_ok;
    logic        rd;

    // Credits count both in-flight requests and words already parked in the
    // FIFO, so every ack has a free slot regardless of consumer back-pressure.
    assign credit_sum = {1'b0, out_q} + {1'b0, cnt_q};
    assign credit_ok  = credit_sum < DEPTH_W;

    assign wb_cyc_o  = (state_q == REQ) || (state_q == WAIT);
    assign wb_stb_o  = (state_q == REQ) && (rem_q != '0) && credit_ok;
    assign wb_we_o   = 1'b0;
    assign wb_adr_o  = adr_q;
    assign busy      = wb_cyc_o;
    assign done      = (state_q == FIN);
    assign out_valid = (cnt_q != '0);
    assign out_data  = mem_q[rptr_q];

    assign issue  = wb_stb_o && !wb_stall_i;
    assign ack_ok = wb_ack_i && (out_q != '0);
    assign rd     = out_valid && out_ready;

    always_comb begin
        out_d = out_q;
        case ({issue, ack_ok})
            2'b10:   out_d = out_q + CW'(1);
            2'b01:   out_d = out_q - CW'(1);
            default: out_d = out_q;
        endcase
        cnt_d = cnt_q;
        case ({ack_ok, rd})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    adr_d   = base;
                    rem_d   = len;
                    state_d = (len != '0) ? REQ : FIN;
                end
            end
            REQ: begin
                if (issue) begin
                    adr_d = adr_q + AW'(1);
                    rem_d = rem_q - LW'(1);
                    if (rem_q == LW'(1)) state_d = WAIT;
                end
            end
            WAIT: begin
                if (out_d == '0) state_d = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            adr_q   <= '0;
            rem_q   <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            rem_q   <= rem_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            if (ack_ok) wptr_q <= wptr_q + PW'(1);
            if (rd)     rptr_q <= rptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (ack_ok) mem_q[wptr_q] <= wb_dat_i;
    end

endmodule
